// File: rtl/alu_issue_ctrl.sv
// Purpose : in-order issue/return controller for the 32-bit ALU (request FIFO -> ALU -> response FIFO).
// Latency : accept to rsp_valid is LAT+2 edges; sustains one op per cycle when the consumer keeps up.
// Backpres: req_ready drops when the request FIFO is full; issue stalls while response credit is zero.
//
// Ports: clk/rst_n (async, active-low); req_valid/req_ready/req_a/req_b/req_sel/req_tag request side;
//        alu_a/alu_b/alu_sel registered ALU drive, alu_y/alu_flag ALU result; rsp_valid/rsp_ready/
//        rsp_y/rsp_flag/rsp_tag/rsp_err response side; busy = anything queued, in flight or buffered.
// Option : define ALU_ISSUE_SELCHK_EN to treat req_sel > 4'b1000 as illegal (issued idle, rsp_err=1,
//          zero result). Without it every sel is forwarded and rsp_err stays 0.

// Purpose : generic synchronous FIFO with occupancy count; read data is zero while empty.
// Latency : write visible at the head one edge after push.
// Backpres: push ignored when full, pop ignored when empty; callers gate with count.
module alu_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Zero when empty so downstream outputs read 0 out of reset.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LAT   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_sel,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_flag,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int RQW  = 2 * WIDTH + 4 + TAG_W;
    localparam int RSW  = WIDTH + 1 + TAG_W + 1;
    // One stage beyond LAT: the tail then sits in the cycle where alu_y is
    // stable for the op, and the capture edge is the one after it.
    localparam int NSTG = LAT + 1;

    logic [RQW-1:0]   req_head;
    logic [RSW-1:0]   rsp_head;
    logic [CW-1:0]    req_count;
    logic [CW-1:0]    rsp_count;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [3:0]       head_sel;
    logic [TAG_W-1:0] head_tag;
    logic             head_err;
    logic             has_credit;
    logic             issue;
    int               inflight_count;
    logic [NSTG-1:0]  pipe_vld;
    logic [NSTG-1:0]  pipe_err;
    logic [TAG_W-1:0] pipe_tag [NSTG];
    logic             tail_vld;
    logic             tail_err;
    logic [WIDTH-1:0] cap_y;
    logic             cap_flag;

    // ---------------- request side ----------------
    assign req_ready = (req_count != CW'(DEPTH));

    alu_issue_fifo #(.W(RQW), .DEPTH(DEPTH)) u_req_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (req_valid),
        .push_dat ({req_a, req_b, req_sel, req_tag}),
        .pop      (issue),
        .pop_dat  (req_head),
        .count    (req_count)
    );

    assign {head_a, head_b, head_sel, head_tag} = req_head;

`ifdef ALU_ISSUE_SELCHK_EN
    assign head_err = (head_sel > 4'b1000);
`else
    assign head_err = 1'b0;
`endif

    // Every issued op is guaranteed a response slot: buffered + in-flight
    // never exceeds DEPTH, so capture can never find the response FIFO full.
    assign inflight_count = $countones(pipe_vld);
    assign has_credit     = (int'(rsp_count) + inflight_count) < DEPTH;
    assign issue          = (req_count != '0) && has_credit;

    // ---------------- ALU drive ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (issue && !head_err) begin
            alu_a   <= head_a;
            alu_b   <= head_b;
            alu_sel <= head_sel;
        end else begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= 4'b1111;
        end
    end

    // ---------------- in-flight tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < NSTG; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_vld    <= {pipe_vld[NSTG-2:0], issue};
            pipe_err    <= {pipe_err[NSTG-2:0], issue && head_err};
            pipe_tag[0] <= head_tag;
            for (int i = 1; i < NSTG; i++) pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    assign tail_vld = pipe_vld[NSTG-1];
    assign tail_err = pipe_err[NSTG-1];
    // Illegal ops never reached the ALU; their result is forced to zero.
    assign cap_y    = tail_err ? '0 : alu_y;
    assign cap_flag = !tail_err && alu_flag;

    // ---------------- response side ----------------
    alu_issue_fifo #(.W(RSW), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tail_vld),
        .push_dat ({cap_y, cap_flag, pipe_tag[NSTG-1], tail_err}),
        .pop      (rsp_ready),
        .pop_dat  (rsp_head),
        .count    (rsp_count)
    );

    assign {rsp_y, rsp_flag, rsp_tag, rsp_err} = rsp_head;
    assign rsp_valid = (rsp_count != '0);
    assign busy      = (req_count != '0) || (inflight_count != 0) || (rsp_count != '0);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_sel;
    logic [TAG_W-1:0] req_tag;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_y;
    logic             alu_flag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_flag;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_sel(req_sel), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_flag(rsp_flag),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    // ---------------- stand-in ALU with LAT-edge result latency ----------------
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return {31'd0, a < b};
            4'd8:    return ~a;
            default: return 32'd0;
        endcase
    endfunction

    logic [WIDTH-1:0] y_pipe [LAT];
    always @(posedge clk) begin
        y_pipe[0] <= alu_f(alu_a, alu_b, alu_sel);
        for (int i = 1; i < LAT; i++) y_pipe[i] <= y_pipe[i-1];
    end
    assign alu_y    = y_pipe[LAT-1];
    assign alu_flag = (alu_y == '0);

    // ---------------- reference model: in-order queue of expected responses ----------------
    typedef struct packed {
        logic [31:0] y;
        logic        flag;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    int   n_rsp = 0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] s, input logic [3:0] t);
        exp_t e;
        e.tag  = t;
        e.err  = 1'b0;
        e.y    = alu_f(a, b, s);
        e.flag = (e.y == 32'd0);
`ifdef ALU_ISSUE_SELCHK_EN
        if (s > 4'd8) begin
            e.y    = 32'd0;
            e.flag = 1'b0;
            e.err  = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Single compare process: handshakes seen here take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            chk("busy", busy, exp_q.size() != 0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    e_cur = exp_q[0];
                    chk("rsp_y",    rsp_y,    e_cur.y);
                    chk("rsp_flag", rsp_flag, e_cur.flag);
                    chk("rsp_tag",  rsp_tag,  e_cur.tag);
                    chk("rsp_err",  rsp_err,  e_cur.err);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        n_rsp++;
                    end
                end
            end
            if (req_valid && req_ready) exp_q.push_back(model(req_a, req_b, req_sel, req_tag));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                        input logic [3:0] t, input int budget);
        bit ok = 1'b0;
        req_a = a; req_b = b; req_sel = s; req_tag = t; req_valid = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", ok, 1'b1);
        if (ok) begin
            @(posedge clk);
            #1;
            n_acc++;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain_idle", (exp_q.size() == 0) && !busy, 1'b1);
    endtask

    logic [31:0] bp_a [12];
    logic [31:0] bp_b [12];
    logic [31:0] seen_y [16];
    logic        seen_f [16];
    logic        seen_e [16];
    bit          seen_sel_a;
    bit          rnd_done;
    int          base, cnt;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0; req_tag = '0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_alu_sel",   alu_sel,   4'd0);
        chk("rst_rsp_y",     rsp_y,     32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- single op: 5+3, tag 2 ----
        rsp_ready = 1'b1;
        send(32'd5, 32'd3, 4'd0, 4'd2, 20);        // now just after edge k
        chk("single_busy", busy, 1'b1);
        @(posedge clk); #1;                         // k+1
        chk("single_alu_sel", alu_sel, 4'd0);
        chk("single_alu_a",   alu_a,   32'd5);
        chk("single_alu_b",   alu_b,   32'd3);
        @(posedge clk); #1;                         // k+2
        chk("single_early", rsp_valid, 1'b0);
        @(posedge clk); #1;                         // k+3
        chk("single_rsp_valid", rsp_valid, 1'b1);
        chk("single_rsp_y",     rsp_y,     32'd8);
        chk("single_rsp_tag",   rsp_tag,   4'd2);
        wait_idle(20);

        // ---- streaming: 8 back-to-back ----
        fork
            for (int i = 0; i < 8; i++) send($urandom, $urandom, 4'($urandom_range(0, 8)), 4'(i), 20);
            begin
                for (int c = 0; c < 20; c++) begin
                    @(posedge clk); #1;
                    if (rsp_valid) break;
                end
                for (int i = 0; i < 8; i++) begin
                    chk("stream_valid", rsp_valid, 1'b1);
                    chk("stream_tag",   rsp_tag,   4'(i));
                    @(posedge clk); #1;
                end
            end
        join
        wait_idle(30);

        // ---- backpressure + full boundary ----
        rsp_ready = 1'b0;
        n_acc = 0;
        base = n_rsp;
        for (int i = 0; i < 12; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        fork
            for (int i = 0; i < 12; i++) send(bp_a[i], bp_b[i], 4'(i % 9), 4'(i), 100);
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("bp_accepted",   n_acc,     8);
                chk("bp_req_ready",  req_ready, 1'b0);
                chk("bp_rsp_valid",  rsp_valid, 1'b1);
                chk("bp_idle_sel",   alu_sel,   4'hF);
                chk("bp_idle_a",     alu_a,     32'd0);
                rsp_ready = 1'b1;                   // free exactly one response slot
                @(posedge clk); #1;
                rsp_ready = 1'b0;
                chk("full_still_full", req_ready, 1'b0);
                @(posedge clk); #1;                 // issue + refused offer on this edge
                chk("full_refused",  n_acc,     8);
                chk("full_count_m1", req_ready, 1'b1);
                chk("full_issue_sel", alu_sel,  4'd4);
                chk("full_issue_a",   alu_a,    bp_a[4]);
                rsp_ready = 1'b1;
            end
        join
        wait_idle(100);
        chk("bp_all_returned", n_rsp - base, 12);

        // ---- illegal opcode between two legal ops ----
        rsp_ready = 1'b1;
        seen_sel_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            seen_y[i] = 'x; seen_f[i] = 1'bx; seen_e[i] = 1'bx;
        end
        fork
            begin
                send(32'd7,  32'd9,  4'd0,    4'd4, 20);
                send(32'd10, 32'd20, 4'b1010, 4'd5, 20);
                send(32'd3,  32'd3,  4'd1,    4'd6, 20);
            end
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                if (alu_sel == 4'b1010) seen_sel_a = 1'b1;
                if (rsp_valid) begin
                    seen_y[rsp_tag] = rsp_y;
                    seen_f[rsp_tag] = rsp_flag;
                    seen_e[rsp_tag] = rsp_err;
                end
            end
        join
        chk("ill_prev_y",    seen_y[4], 32'd16);
        chk("ill_next_y",    seen_y[6], 32'd0);
        chk("ill_next_flag", seen_f[6], 1'b1);
`ifdef ALU_ISSUE_SELCHK_EN
        chk("ill_alu_sel_seen", seen_sel_a, 1'b0);
        chk("ill_rsp_err",      seen_e[5],  1'b1);
        chk("ill_rsp_y",        seen_y[5],  32'd0);
`else
        chk("ill_alu_sel_seen", seen_sel_a, 1'b1);
        chk("ill_rsp_err",      seen_e[5],  1'b0);
`endif
        wait_idle(30);

        // ---- randomized traffic with random consumer stalls ----
        rnd_done = 1'b0;
        base = n_rsp;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send($urandom, $urandom, 4'($urandom_range(0, 15)), 4'(i), 200);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        wait_idle(300);
        chk("rnd_all_returned", n_rsp - base, 150);

        // ---- mid-cycle reset with ops in flight ----
        rsp_ready = 1'b0;
        send(32'd1, 32'd2, 4'd0, 4'd1, 20);
        send(32'd3, 32'd4, 4'd0, 4'd2, 20);
        send(32'd5, 32'd6, 4'd0, 4'd3, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", req_ready, 1'b1);
        chk("mrst_rsp_valid", rsp_valid, 1'b0);
        chk("mrst_busy",      busy,      1'b0);
        chk("mrst_alu_sel",   alu_sel,   4'd0);
        chk("mrst_rsp_tag",   rsp_tag,   4'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        rsp_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid) cnt++;
        end
        chk("mrst_no_rsp", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
